// File: rtl/x_down_counter_pkg.sv
// x_down_counter_pkg: shared width constant and state encoding for the down counter
package x_down_counter_pkg;
  localparam int WIDTH = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/x_down_counter_8_bit.sv
// x_down_counter_8_bit: loadable 8-bit down counter with one-shot or auto-reload expiry pulse
module x_down_counter_8_bit
  import x_down_counter_pkg::*;
#(
  parameter int RELOAD = 0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_load_7,
  input  logic i_load_6,
  input  logic i_load_5,
  input  logic i_load_4,
  input  logic i_load_3,
  input  logic i_load_2,
  input  logic i_load_1,
  input  logic i_load_0,
  input  logic i_start,
  input  logic i_abort,
  output logic o_busy,
  output logic o_done,
  output logic o_count_7,
  output logic o_count_6,
  output logic o_count_5,
  output logic o_count_4,
  output logic o_count_3,
  output logic o_count_2,
  output logic o_count_1,
  output logic o_count_0
);
  logic [WIDTH-1:0] load_val, count_q, count_d, reload_q, reload_d;
  state_t state_q, state_d;
  logic rearm;
  assign load_val = {i_load_7, i_load_6, i_load_5, i_load_4, i_load_3, i_load_2, i_load_1, i_load_0};
  assign rearm = (RELOAD != 0) && (reload_q != '0);
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    reload_d = reload_q;
    if (i_abort && state_q != IDLE) state_d = IDLE;
    else
      unique case (state_q)
        IDLE:
          if (i_load) begin
            count_d = load_val;
            reload_d = load_val;
          end else if (i_start) state_d = (count_q == '0) ? DONE : RUN;
        RUN: begin
          count_d = (count_q == '0) ? count_q : count_q - WIDTH'(1);
          state_d = (count_q <= WIDTH'(1)) ? DONE : RUN;
        end
        DONE: begin
          state_d = rearm ? RUN : IDLE;
          count_d = rearm ? reload_q : '0;
        end
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state_q <= IDLE;
      count_q <= '0;
      reload_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      reload_q <= reload_d;
    end
  assign o_busy = (state_q != IDLE);
  assign o_done = (state_q == DONE);
  assign {o_count_7, o_count_6, o_count_5, o_count_4, o_count_3, o_count_2, o_count_1, o_count_0} = count_q;
endmodule

// File: tb/tb_x_down_counter_8_bit.sv
// tb_x_down_counter_8_bit: one-shot and auto-reload instances checked against a behavioural timer model
module tb_x_down_counter_8_bit;
  logic clk = 1'b0, rst = 1'b1, ld = 1'b0, st = 1'b0, ab = 1'b0;
  logic [7:0] val = 8'd0;
  logic b0, d0, b1, d1;
  logic [7:0] c0, c1;
  int checks = 0, errors = 0;
  logic [7:0] m_cnt [2], m_rel [2];
  bit m_busy [2], m_done [2];

  typedef struct {
    bit l, s, a;
    logic [7:0] v;
    bit eb, ed;
    logic [7:0] ec;
  } vec_t;
  vec_t tbl [15];

  always #5 clk = ~clk;

  x_down_counter_8_bit #(.RELOAD(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_load(ld),
    .i_load_7(val[7]), .i_load_6(val[6]), .i_load_5(val[5]), .i_load_4(val[4]),
    .i_load_3(val[3]), .i_load_2(val[2]), .i_load_1(val[1]), .i_load_0(val[0]),
    .i_start(st), .i_abort(ab), .o_busy(b0), .o_done(d0),
    .o_count_7(c0[7]), .o_count_6(c0[6]), .o_count_5(c0[5]), .o_count_4(c0[4]),
    .o_count_3(c0[3]), .o_count_2(c0[2]), .o_count_1(c0[1]), .o_count_0(c0[0])
  );

  x_down_counter_8_bit #(.RELOAD(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_load(ld),
    .i_load_7(val[7]), .i_load_6(val[6]), .i_load_5(val[5]), .i_load_4(val[4]),
    .i_load_3(val[3]), .i_load_2(val[2]), .i_load_1(val[1]), .i_load_0(val[0]),
    .i_start(st), .i_abort(ab), .o_busy(b1), .o_done(d1),
    .o_count_7(c1[7]), .o_count_6(c1[6]), .o_count_5(c1[5]), .o_count_4(c1[4]),
    .o_count_3(c1[3]), .o_count_2(c1[2]), .o_count_1(c1[1]), .o_count_0(c1[0])
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", n, act, exp);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_rel[i] = 0; m_busy[i] = 0; m_done[i] = 0;
    end
  endtask

  // Timer seen as "busy counting down, then one expiry cycle"; auto-reload re-arms from the stored value.
  task automatic mstep(input int i);
    if (ab && m_busy[i]) begin
      m_busy[i] = 0; m_done[i] = 0;
    end else if (!m_busy[i]) begin
      if (ld) begin m_cnt[i] = val; m_rel[i] = val; end
      else if (st) begin m_busy[i] = 1; m_done[i] = (m_cnt[i] == 0); end
    end else if (m_done[i]) begin
      if (i == 1 && m_rel[i] != 0) begin m_cnt[i] = m_rel[i]; m_done[i] = 0; end
      else begin m_busy[i] = 0; m_done[i] = 0; m_cnt[i] = 0; end
    end else begin
      m_cnt[i] = m_cnt[i] - 8'd1;
      m_done[i] = (m_cnt[i] == 0);
    end
  endtask

  task automatic drive(input bit l, input bit s, input bit a, input logic [7:0] v);
    ld = l; st = s; ab = a; val = v;
    @(posedge clk);
    mstep(0);
    mstep(1);
    #1;
    chk("model_oneshot", {b0, d0, c0}, {m_busy[0], m_done[0], m_cnt[0]});
    chk("model_reload", {b1, d1, c1}, {m_busy[1], m_done[1], m_cnt[1]});
    ld = 0; st = 0; ab = 0;
  endtask

  initial begin
    int n;
    tbl[0]  = '{1, 0, 0, 8'd5, 0, 0, 8'd5};
    tbl[1]  = '{0, 1, 0, 8'd0, 1, 0, 8'd5};
    tbl[2]  = '{0, 0, 0, 8'd0, 1, 0, 8'd4};
    tbl[3]  = '{0, 0, 0, 8'd0, 1, 0, 8'd3};
    tbl[4]  = '{0, 0, 0, 8'd0, 1, 0, 8'd2};
    tbl[5]  = '{0, 0, 0, 8'd0, 1, 0, 8'd1};
    tbl[6]  = '{0, 0, 0, 8'd0, 1, 1, 8'd0};
    tbl[7]  = '{0, 0, 0, 8'd0, 0, 0, 8'd0};
    tbl[8]  = '{1, 1, 0, 8'd9, 0, 0, 8'd9};
    tbl[9]  = '{0, 0, 1, 8'd0, 0, 0, 8'd9};
    tbl[10] = '{0, 1, 0, 8'd0, 1, 0, 8'd9};
    tbl[11] = '{1, 0, 0, 8'd3, 1, 0, 8'd8};
    tbl[12] = '{0, 0, 1, 8'd0, 0, 0, 8'd8};
    tbl[13] = '{0, 1, 0, 8'd0, 1, 0, 8'd8};
    tbl[14] = '{0, 0, 1, 8'd0, 0, 0, 8'd8};
    mreset();
    #3;
    chk("reset_state0", {b0, d0, c0}, 10'd0);
    chk("reset_state1", {b1, d1, c1}, 10'd0);
    #19 rst = 0;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      drive(tbl[i].l, tbl[i].s, tbl[i].a, tbl[i].v);
      chk($sformatf("tbl%0d", i), {b0, d0, c0}, {tbl[i].eb, tbl[i].ed, tbl[i].ec});
    end

    drive(1, 0, 0, 8'd10);
    drive(0, 1, 0, 8'd0);
    drive(0, 0, 0, 8'd0);
    drive(0, 0, 0, 8'd0);
    drive(0, 0, 0, 8'd0);
    chk("run_at_7", {b0, c0}, {1'b1, 8'd7});
    #2 rst = 1;
    #1;
    chk("async_rst0", {b0, d0, c0}, 10'd0);
    chk("async_rst1", {b1, d1, c1}, 10'd0);
    mreset();
    #3 rst = 0;
    drive(0, 1, 0, 8'd0);
    chk("start_no_load", {b0, d0, c0}, {1'b1, 1'b1, 8'd0});
    drive(0, 0, 0, 8'd0);
    chk("after_zero_done", {b0, d0, c0}, 10'd0);

    drive(1, 0, 0, 8'd3);
    drive(0, 1, 0, 8'd0);
    drive(1, 0, 0, 8'd7);
    for (int p = 0; p < 3; p++) begin
      n = 0;
      while (!d1 && n < 20) begin drive(0, 0, 0, 8'd0); n++; end
      chk("reload_pulse_seen", d1, 1'b1);
      drive(0, 0, 0, 8'd0);
      chk("reload_value_kept", c1, 8'd3);
      n = 1;
      while (!d1 && n < 20) begin drive(0, 0, 0, 8'd0); n++; end
      chk("reload_period", n, 4);
    end
    n = 0;
    while (!(b1 && !d1 && c1 == 8'd2) && n < 20) begin drive(0, 0, 0, 8'd0); n++; end
    drive(0, 0, 1, 8'd0);
    chk("abort_at_2", {b1, d1, c1}, {1'b0, 1'b0, 8'd2});
    n = 0;
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 0, 8'd0);
      if (d1 || b1) n++;
    end
    chk("no_done_after_abort", n, 0);

    drive(1, 0, 0, 8'hFF);
    drive(0, 1, 0, 8'd0);
    n = 0;
    while (!d0 && n < 400) begin drive(0, 0, 0, 8'd0); n++; end
    chk("ff_latency", n, 255);
    drive(0, 0, 1, 8'd0);
    drive(0, 0, 0, 8'd0);

    for (int k = 0; k < 400; k++)
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0,
             $urandom_range(0, 1) ? 8'($urandom_range(0, 6)) : 8'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/x_down_counter_8_bit.md
X_DOWN_COUNTER_8_BIT -- requirements
Module: x_down_counter_8_bit

Interface
REQ-001 Parameter RELOAD, default 0, meaning 1 = auto-reload from stored load value after each expiry, 0 = one-shot.
REQ-002 i_clk  in  1  single clock; all state changes on posedge.
REQ-003 i_rst  in  1  reset, asynchronous assert, active-high.
REQ-004 i_load  in  1  strobe: capture i_load_7..i_load_0.
REQ-005 i_load_7 .. i_load_0  in  1 each  load value bits, i_load_7 = MSB.
REQ-006 i_start  in  1  strobe: begin countdown.
REQ-007 i_abort  in  1  strobe: cancel countdown.
REQ-008 o_busy  out  1  high whenever state is not IDLE.
REQ-009 o_done  out  1  single-cycle expiry pulse.
REQ-010 o_count_7 .. o_count_0  out  1 each  current count bits, o_count_7 = MSB, driven directly from the count register.

Function
REQ-011 Registers: count_q[7:0], reload_q[7:0], state_q in {IDLE, RUN, DONE}.
REQ-012 IDLE with i_load: count_q and reload_q both take the value on {i_load_7..i_load_0}; i_start in the same cycle is ignored.
REQ-013 IDLE with i_start, no i_load, count_q != 0: go to RUN; count_q holds.
REQ-014 IDLE with i_start, no i_load, count_q == 0: go directly to DONE.
REQ-015 RUN: count_q decrements by 1 each cycle; on the edge where count_q goes 1 -> 0, state goes to DONE.
REQ-016 Latency: with loaded value N and i_start sampled at edge k, count_q reaches 0 at edge k+N, and o_done is high only in the cycle following edge k+N (N = 0 included).
REQ-017 DONE lasts exactly one cycle and o_done = (state_q == DONE), with no combinational path from inputs.
REQ-018 Leaving DONE when RELOAD = 1 and reload_q != 0: go to RUN with count_q = reload_q, giving an o_done period of N+1 cycles.
REQ-019 Leaving DONE when RELOAD = 0, or when reload_q == 0: go to IDLE with count_q = 0.
REQ-020 i_abort in RUN or DONE: go to IDLE next edge; count_q holds its current value; o_done is not asserted in the following cycle.
REQ-021 i_abort has priority over every other event; in IDLE it has no effect.
REQ-022 i_load and i_start outside IDLE are ignored; reload_q changes only in IDLE.
REQ-023 No wrap-around: count_q never decrements below 0; 8-bit unsigned arithmetic only.

Reset
REQ-024 i_rst high forces, asynchronously: state_q = IDLE, count_q = 0, reload_q = 0, o_busy = 0, o_done = 0, all o_count_* = 0.
REQ-025 Reset mid-countdown discards the countdown; after release the block is in IDLE, and the first i_start without a prior load goes to DONE per REQ-014.

Structure
REQ-026 Shared package x_down_counter_pkg holds the WIDTH = 8 constant and the state enum typedef (IDLE, RUN, DONE).
REQ-027 Single flat module with no sub-module; next-state and next-count logic live in one combinational block feeding one always_ff block.

Verification
REQ-028 Load 5, start -> o_busy high 6 cycles; o_count sequence 5,4,3,2,1,0; o_done high only in the cycle after count reaches 0; then IDLE.
REQ-029 Reset, then start without a load -> o_done pulses in the next cycle, and o_count stays 0.
REQ-030 RELOAD = 1, load 3, start -> o_done pulses every 4 cycles indefinitely; abort while count = 2 -> IDLE, o_count = 2, no further o_done.
REQ-031 Load 8'hFF, start -> o_done exactly 255 cycles after start; load with start asserted in the same cycle -> no start, and the new value is held.
REQ-032 Assert i_rst mid-RUN at count 7 -> outputs zero immediately, without waiting for a clock edge; i_load asserted during RUN -> reload_q unchanged.
